// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-source round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_SRC = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [N_SRC-1:0] SEL_RST = 4'b0000;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set bit of req scanning from start
// upward, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = 3; k >= 0; k--) begin
      if (req[start + 2'(k)]) begin
        found = 1'b1;
        idx   = start + 2'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the one-hot select of a shared 4-source mux,
// with a per-grant hold limit and direct regrant between owners.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] sel,
  output logic [1:0]       sel_idx,
  output logic             busy
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   sel_q, sel_d;
  logic [1:0]         sel_idx_q, sel_idx_d;
  logic               busy_q, busy_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [1:0]         last_q, last_d;

  logic [1:0]         pick_start;
  logic               pick_found;
  logic [1:0]         pick_idx;

  // In GRANT the owner is always last_q, so one search from last_q+1 serves
  // both the idle pick and the release regrant.
  assign pick_start = last_q + 2'd1;

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_idx_d = sel_idx_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    last_d    = last_q;

    if (state_q == GRANT && req[last_q] && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end else if (pick_found) begin
      // Fresh grant from IDLE or regrant on release; the owner itself is
      // only reached last in the search, so it wins only when alone.
      state_d   = GRANT;
      sel_d     = 4'b0001 << pick_idx;
      sel_idx_d = pick_idx;
      busy_d    = 1'b1;
      hold_d    = '0;
      last_d    = pick_idx;
    end else begin
      state_d   = IDLE;
      sel_d     = SEL_RST;
      sel_idx_d = 2'd0;
      busy_d    = 1'b0;
      hold_d    = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the asynchronous reset clears sel without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_RST;
      sel_idx_q <= 2'd0;
      busy_q    <= 1'b0;
      hold_q    <= '0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_idx_q <= sel_idx_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  assign sel     = sel_q;
  assign sel_idx = sel_idx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter with MAX_HOLD=8, plus a random
// soak for one-hot select and bounded waiting.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] sel;
  logic [1:0] sel_idx;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .sel_idx (sel_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] s);
    case (s)
      4'b0010: idx_of = 2'd1;
      4'b0100: idx_of = 2'd2;
      4'b1000: idx_of = 2'd3;
      default: idx_of = 2'd0;
    endcase
  endfunction

  // Outputs are driven and sampled on the falling edge, half a cycle from
  // the active edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_sel);
    check({tag, ".sel"}, 32'(sel), 32'(exp_sel));
    check({tag, ".idx"}, 32'(sel_idx), 32'(idx_of(exp_sel)));
    check({tag, ".busy"}, 32'(busy), 32'(exp_sel != 4'b0000));
  endtask

  logic [3:0] rq;
  int         wait_cnt [4];
  int         max_wait;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    step();
    step();
    check_out("reset", 4'b0000);
    check("reset.hold", 32'(dut.hold_q), 32'd0);

    // All four requesting: 8-cycle grants rotating 0,1,2,3,0.
    rst = 1'b0;
    req = 4'b1111;
    for (int n = 1; n <= 33; n++) begin
      step();
      check_out($sformatf("all_req.c%0d", n), 4'b0001 << (((n - 1) / 8) % 4));
    end
    req = 4'b0000;
    step();
    check_out("all_req.drop", 4'b0000);

    // Single short request from source 2.
    req = 4'b0100;
    for (int n = 1; n <= 3; n++) begin
      step();
      check_out($sformatf("short.c%0d", n), 4'b0100);
    end
    req = 4'b0000;
    step();
    check_out("short.drop", 4'b0000);

    // Lone requester past the hold limit: regranted to itself, counter restarts.
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      step();
      check_out($sformatf("lone.c%0d", c), 4'b0100);
      check($sformatf("lone.hold.c%0d", c), 32'(dut.hold_q), 32'(c % MAX_HOLD));
    end
    req = 4'b0000;
    step();
    check_out("lone.drop", 4'b0000);

    // Owner 1 drops while 3 waits: direct handover, no empty cycle.
    req = 4'b0010;
    step();
    check_out("handover.grant1", 4'b0010);
    req = 4'b1010;
    step();
    check_out("handover.keep1", 4'b0010);
    req = 4'b1000;
    step();
    check_out("handover.to3", 4'b1000);
    req = 4'b0000;
    step();
    check_out("handover.idle", 4'b0000);

    // Asynchronous reset between edges clears the grant at once.
    req = 4'b0001;
    step();
    check_out("async.grant0", 4'b0001);
    #2 rst = 1'b1;
    #1;
    check_out("async.cleared", 4'b0000);
    step();
    rst = 1'b0;
    req = 4'b1010;
    step();
    check_out("async.after", 4'b0010);

    // Random soak: sel one-hot or zero, outputs consistent, bounded waits.
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      rq  = 4'($urandom);
      req = rq;
      step();
      check("rand.onehot0", 32'((sel & (sel - 4'd1)) == 4'd0), 32'd1);
      check("rand.idx", 32'(sel_idx), 32'(idx_of(sel)));
      check("rand.busy", 32'(busy), 32'(sel != 4'b0000));
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && !sel[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    check("rand.max_wait_ok", 32'(max_wait <= 3 * MAX_HOLD), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
